xorcollapse: RTL and testbench
==============================

# xorcollapse

Serial decoder for the pairwise-XOR expansion produced by `xorexpand`. It consumes the expanded vector `p` one bit per handshake, in ascending index order, and reconstructs the random vector `r`. Because the expansion is invariant under complementing `r`, the caller supplies `r[0]`. The block optionally checks every redundant pair for consistency and reports the first bad index. It sits on the evaluator side of the garbled display path and is used for self-test and debug of the `r` → `p` expansion.

## Interface
- `RNDSIZE`, default 16: width of `r`; must be ≥ 2. Instantiated from the `` `RNDSIZE `` macro.
- `NP` (localparam) = RNDSIZE*(RNDSIZE-1)/2: number of `p` bits.
- `KW` (localparam) = $clog2(NP), minimum 1: index width.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins a decode; sampled in IDLE only.
- `r0` in 1: value of `r[0]`; sampled together with `start`.
- `p_valid` in 1: `p_bit` is valid.
- `p_bit` in 1: next expansion bit, index `k` ascending from 0.
- `p_ready` out 1: block accepts a bit this cycle.
- `busy` out 1: high in RECOVER and CHECK.
- `r_out` out RNDSIZE: reconstructed `r`, with `r_out[i]` = `r[i]`.
- `r_valid` out 1: one-cycle pulse; `r_out` and `mismatch` are final.
- `mismatch` out 1: sticky flag; a consistency error was detected.
- `err_k` out KW: index `k` of the first mismatching bit.

## Operation
- Bit index map, identical to the encoder: pair (i,j) with i<j maps to `k` = i*RNDSIZE − i*(i+1)/2 + j − i − 1. The stream order is i outer, j inner, and `p[k]` = `r[i]^r[j]`.
- Internal counters: `i`, `j`, and `k`. `k` is KW bits wide and never exceeds NP−1.
- States:
  - **IDLE:** `p_ready`=0. If `start` is high, the block loads `r_out`={RNDSIZE-1 zeros, r0}, clears `mismatch` and `err_k`, sets i=0, j=1, k=0, and moves to RECOVER.
  - **RECOVER (i=0):** `p_ready`=1. On each transfer (`p_valid & p_ready`), `r_out[j]` ← `r0 ^ p_bit`.
    - If j=RNDSIZE−1: if RNDSIZE=2 go to DONE; otherwise set i=1, j=2 and go to CHECK.
    - Otherwise j++.
    - `k` increments on every transfer.
  - **CHECK (i≥1):** `p_ready`=1. On each transfer, compare `p_bit` with `r_out[i]^r_out[j]`.
    - On inequality with `mismatch`=0: set `mismatch`=1 and `err_k`=k. Later errors leave `err_k` unchanged.
    - Advance j; when j wraps past RNDSIZE−1, set i++ and j=i+1.
    - The transfer at k=NP−1 moves to DONE.
  - **DONE:** `r_valid`=1 for exactly one cycle, then IDLE.
- `r_out`, `mismatch`, and `err_k` hold their values until the next accepted `start`.
- `start` is ignored outside IDLE.
- `start` in the DONE cycle is ignored, so the earliest restart is the cycle after `r_valid`.
- `p_valid` in IDLE is ignored; no bits are consumed.

## Timing
- Reset values: state IDLE, `p_ready`=0, `busy`=0, `r_out`=0, `r_valid`=0, `mismatch`=0, `err_k`=0.
- `start` sampled at cycle t: `p_ready`=1 from cycle t+1.
- The last transfer at cycle u gives `r_valid`=1 at cycle u+1 and IDLE at u+2.
- With `p_valid` held high: `r_valid` arrives NP+1 cycles after the `start` edge.
- `p_ready` is a function of state only. It never depends combinationally on `p_valid`.
- `p_valid` gaps stall the block with all counters held. There is no timeout.
- `rst_n` low mid-decode aborts immediately to the reset values. No `r_valid` is produced.

## Configuration
- `XORCOLLAPSE_CHECK_EN` defined: CHECK compares bits and drives `mismatch` and `err_k` as described.
- `XORCOLLAPSE_CHECK_EN` undefined: CHECK still accepts and discards the remaining NP−RNDSIZE+1 bits, so the stream protocol is unchanged. `mismatch` and `err_k` are tied to 0 and the comparator is removed.

## Test plan
All cases use RNDSIZE=4, so NP=6. Pair order: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- **Nominal decode:** `r0`=1; stream k0..5 = 0,1,0,1,0,1 back to back → `r_out`=4'b1011, `mismatch`=0, and `r_valid` exactly 7 cycles after `start`.
- **Complement ambiguity:** same stream, `r0`=0 → `r_out`=4'b0100, `mismatch`=0.
- **Corruption:** same stream with k4 flipped to 1, then k5 also flipped → `mismatch`=1, `err_k`=4. The first error is retained. Without `XORCOLLAPSE_CHECK_EN`: `mismatch`=0 and `r_out`=4'b1011.
- **Backpressure and ignored inputs:** `p_valid` toggles 1,0,0,1 per cycle → same `r_out`, and no bit is consumed while `p_valid`=0. `start` pulsed mid-stream has no effect.
- **Reset abort:** `rst_n` low after 3 transfers → all outputs return to 0 with no `r_valid`. A fresh decode then completes with the correct result.
- **Random regression:** 1000 random `r` encoded by `xorexpand` are fed through the block → `r_out`==`r` whenever `r0`=`r[0]`, with `mismatch`=0 in every case.

Source files
------------

// File: rtl/xorcollapse_if.sv
// -----------------------------------------------------------------------------
// xorcollapse_if
// Handshake and result bundle for the xorcollapse serial decoder.
//
// Parameter:
//   RNDSIZE  width of the reconstructed vector r (>= 2), defaults to `RNDSIZE
//
// Signals (direction seen from the decoder, i.e. the slave modport):
//   start     in   begin a decode (sampled in IDLE only)
//   r0        in   value of r[0], sampled with start
//   p_valid   in   p_bit carries a valid expansion bit
//   p_bit     in   next expansion bit, ascending index k
//   p_ready   out  decoder accepts a bit this cycle
//   busy      out  decode in progress
//   r_out     out  reconstructed r
//   r_valid   out  one-cycle pulse, r_out / mismatch / err_k final
//   mismatch  out  sticky consistency-error flag
//   err_k     out  index of the first inconsistent bit
// -----------------------------------------------------------------------------
`ifndef RNDSIZE
`define RNDSIZE 16
`endif

interface xorcollapse_if #(
  parameter int RNDSIZE = `RNDSIZE
);
  localparam int NP = RNDSIZE * (RNDSIZE - 1) / 2;
  localparam int KW = (NP > 1) ? $clog2(NP) : 1;

  logic               start;
  logic               r0;
  logic               p_valid;
  logic               p_bit;
  logic               p_ready;
  logic               busy;
  logic [RNDSIZE-1:0] r_out;
  logic               r_valid;
  logic               mismatch;
  logic [KW-1:0]      err_k;

  // Producer side: drives the request and the bit stream.
  modport master (
    output start, r0, p_valid, p_bit,
    input  p_ready, busy, r_out, r_valid, mismatch, err_k
  );

  // Decoder side.
  modport slave (
    input  start, r0, p_valid, p_bit,
    output p_ready, busy, r_out, r_valid, mismatch, err_k
  );
endinterface

// File: rtl/xorcollapse.sv
// -----------------------------------------------------------------------------
// xorcollapse
// Serial decoder for the pairwise-XOR expansion p[k] = r[i]^r[j] (i<j, i outer,
// j inner). Bits arrive one per handshake in ascending k. The first RNDSIZE-1
// bits (pairs (0,j)) fully determine r given r[0]; the remaining bits are
// redundant and are optionally checked for consistency.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    xorcollapse_if.slave: start/r0 request, p_valid/p_bit/p_ready
//          stream, busy, r_out, r_valid, mismatch, err_k results
//
// Configuration macros:
//   RNDSIZE               default width of r (16 if undefined)
//   XORCOLLAPSE_CHECK_EN  when defined, redundant pairs are compared and the
//                         first bad index is reported; when undefined the
//                         redundant bits are consumed and discarded, and
//                         mismatch/err_k are tied to zero.
// -----------------------------------------------------------------------------
`ifndef RNDSIZE
`define RNDSIZE 16
`endif

module xorcollapse #(
  parameter int RNDSIZE = `RNDSIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  xorcollapse_if.slave  bus
);

  localparam int NP = RNDSIZE * (RNDSIZE - 1) / 2;
  localparam int KW = (NP > 1) ? $clog2(NP) : 1;
  localparam int IW = $clog2(RNDSIZE);

  localparam logic [IW-1:0] LAST_J = IW'(RNDSIZE - 1);
  localparam logic [KW-1:0] LAST_K = KW'(NP - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECOVER = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]         r_state;
  logic [IW-1:0]      r_i;
  logic [IW-1:0]      r_j;
  logic [KW-1:0]      r_k;
  logic [RNDSIZE-1:0] r_rout;

  logic w_ready;
  logic w_xfer;
  logic w_start_acc;

  // Ready depends on state only, never on p_valid.
  assign w_ready     = (r_state == S_RECOVER) || (r_state == S_CHECK);
  assign w_xfer      = w_ready & bus.p_valid;
  assign w_start_acc = (r_state == S_IDLE) & bus.start;

  assign bus.p_ready = w_ready;
  assign bus.busy    = w_ready;
  assign bus.r_valid = (r_state == S_DONE);
  assign bus.r_out   = r_rout;

  // Control and reconstruction. r_out[0] holds r0 for the whole decode, so it
  // doubles as the reference bit during RECOVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_rout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rout  <= {{(RNDSIZE-1){1'b0}}, bus.r0};
            r_i     <= '0;
            r_j     <= IW'(1);
            r_k     <= '0;
            r_state <= S_RECOVER;
          end
        end

        S_RECOVER: begin
          if (w_xfer) begin
            r_rout[r_j] <= r_rout[0] ^ bus.p_bit;
            // k saturates at NP-1; only the RNDSIZE=2 case ends here.
            if (r_k != LAST_K) begin
              r_k <= r_k + 1'b1;
            end
            if (r_j == LAST_J) begin
              if (RNDSIZE == 2) begin
                r_state <= S_DONE;
              end else begin
                r_i     <= IW'(1);
                r_j     <= IW'(2);
                r_state <= S_CHECK;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end

        S_CHECK: begin
          if (w_xfer) begin
            if (r_k == LAST_K) begin
              // Final pair; counters are left as-is and reloaded on next start.
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + 1'b1;
              if (r_j == LAST_J) begin
                r_i <= r_i + 1'b1;
                r_j <= r_i + IW'(2);
              end else begin
                r_j <= r_j + 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef XORCOLLAPSE_CHECK_EN
  logic          r_mismatch;
  logic [KW-1:0] r_err_k;
  logic          w_bad;

  // Redundant bit disagrees with the pair recovered from the first row.
  assign w_bad = bus.p_bit ^ r_rout[r_i] ^ r_rout[r_j];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
      r_err_k    <= '0;
    end else if (w_start_acc) begin
      r_mismatch <= 1'b0;
      r_err_k    <= '0;
    end else if ((r_state == S_CHECK) && w_xfer && w_bad && !r_mismatch) begin
      // Only the first error is recorded; later ones leave err_k alone.
      r_mismatch <= 1'b1;
      r_err_k    <= r_k;
    end
  end

  assign bus.mismatch = r_mismatch;
  assign bus.err_k    = r_err_k;
`else
  assign bus.mismatch = 1'b0;
  assign bus.err_k    = '0;
`endif

endmodule

// File: tb/tb_xorcollapse.sv
// -----------------------------------------------------------------------------
// tb_xorcollapse
// Scoreboard bench for xorcollapse with RNDSIZE=4 (NP=6). Each issued decode
// pushes its expected result; a forked monitor pops and compares on every
// r_valid pulse. Expected results come from a reference model that rebuilds r
// from the pair index formula and scans all redundant pairs.
// -----------------------------------------------------------------------------
module tb_xorcollapse;

  localparam int RN = 4;
  localparam int NP = RN * (RN - 1) / 2;
  localparam int KW = $clog2(NP);

  typedef struct packed {
    logic [RN-1:0] r;
    logic          m;
    logic [KW-1:0] e;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  xorcollapse_if #(.RNDSIZE(RN)) bus ();

  xorcollapse #(.RNDSIZE(RN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   rv_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Encoder: p[k] = r[i]^r[j] for every pair i<j.
  function automatic logic [NP-1:0] expand(input logic [RN-1:0] r);
    logic [NP-1:0] p;
    int k;
    p = '0;
    for (int i = 0; i < RN; i++)
      for (int j = i + 1; j < RN; j++) begin
        k = i * RN - i * (i + 1) / 2 + j - i - 1;
        p[k] = r[i] ^ r[j];
      end
    return p;
  endfunction

  // Reference decoder: r[j] from pair (0,j), then first inconsistent pair.
  function automatic exp_t model(input bit r0v, input logic [NP-1:0] p);
    exp_t e;
    logic [RN-1:0] r;
    int k;
    e = '0;
    r = '0;
    r[0] = r0v;
    for (int j = 1; j < RN; j++) begin
      k = j - 1;
      r[j] = r0v ^ p[k];
    end
    e.r = r;
`ifdef XORCOLLAPSE_CHECK_EN
    for (int i = 1; i < RN; i++)
      for (int j = i + 1; j < RN; j++) begin
        k = i * RN - i * (i + 1) / 2 + j - i - 1;
        if (!e.m && (p[k] != (r[i] ^ r[j]))) begin
          e.m = 1'b1;
          e.e = KW'(k);
        end
      end
`else
    k = 0;
`endif
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (rst_n && bus.r_valid === 1'b1) begin
        rv_cyc = cyc;
        if (sbq.size() == 0) begin
          check("spurious_r_valid", 32'(bus.r_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          a = {bus.r_out, bus.mismatch, bus.err_k};
          n_cmp++;
          if (a !== e) begin
            n_bad++;
            $display("FAIL result: got r_out=%b mismatch=%b err_k=%0d, expected r_out=%b mismatch=%b err_k=%0d",
                     a.r, a.m, a.e, e.r, e.m, e.e);
          end
        end
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sbq.size() != 0) begin
      check("r_valid_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  // mode 0: p_valid always high; 1: 1,0,0,1 pattern; 2: random gaps.
  task automatic decode(input bit r0v, input logic [NP-1:0] p, input exp_t e,
                        input int mode, input bit poke_start, input int abort_at,
                        output int start_cyc);
    int  idx;
    int  guard;
    bit  v;
    bit  xfer;
    idx   = 0;
    guard = 0;
    bus.start = 1'b1;
    bus.r0    = r0v;
    start_cyc = cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("p_ready_after_start", 32'(bus.p_ready), 32'd1);
    while (idx < NP && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 4 == 0) || (guard % 4 == 3);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.p_valid = v;
      bus.p_bit   = v ? p[idx] : 1'($urandom);
      bus.start   = (poke_start && guard == 2);
      bus.r0      = 1'($urandom);
      xfer = v && (bus.p_ready === 1'b1);
      @(posedge clk); #1;
      guard++;
      if (xfer) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              32'({bus.p_ready, bus.busy, bus.r_valid, bus.mismatch, bus.err_k, bus.r_out}), 32'd0);
        void'(sbq.pop_back());
        bus.p_valid = 1'b0;
        bus.start   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (NP + 4) @(posedge clk);
        #1;
        return;
      end
    end
    bus.p_valid = 1'b0;
    bus.start   = 1'b0;
    if (guard >= 400) check("stream_timeout", 32'(idx), 32'(NP));
    drain();
    check("hold_r_out", 32'(bus.r_out), 32'(e.r));
    check("idle_not_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] p_nom;
    logic [NP-1:0] p;
    logic [RN-1:0] r;
    exp_t          e;
    int            sc;
    bit            r0v;

    bus.start   = 1'b0;
    bus.r0      = 1'b0;
    bus.p_valid = 1'b0;
    bus.p_bit   = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({bus.p_ready, bus.busy, bus.r_valid, bus.mismatch, bus.err_k, bus.r_out}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // p = 0,1,0,1,0,1 for k = 0..5
    p_nom = 6'b101010;

    // Nominal decode with latency check.
    e = '{r: 4'b1011, m: 1'b0, e: '0};
    decode(1'b1, p_nom, e, 0, 1'b0, -1, sc);
    check("latency", 32'(rv_cyc - sc), 32'd7);

    // Complement ambiguity.
    e = '{r: 4'b0100, m: 1'b0, e: '0};
    decode(1'b0, p_nom, e, 0, 1'b0, -1, sc);

    // Corruption: k4 flipped, then k4 and k5 flipped.
`ifdef XORCOLLAPSE_CHECK_EN
    e = '{r: 4'b1011, m: 1'b1, e: 3'd4};
`else
    e = '{r: 4'b1011, m: 1'b0, e: '0};
`endif
    decode(1'b1, 6'b111010, e, 0, 1'b0, -1, sc);
    decode(1'b1, 6'b011010, e, 0, 1'b0, -1, sc);

    // Backpressure with a start pulse mid-stream.
    e = '{r: 4'b1011, m: 1'b0, e: '0};
    decode(1'b1, p_nom, e, 1, 1'b1, -1, sc);

    // Reset abort after 3 transfers, then a fresh decode.
    decode(1'b1, p_nom, e, 0, 1'b0, 3, sc);
    decode(1'b1, p_nom, e, 0, 1'b0, -1, sc);

    // Random regression: encoded r, mostly with the matching r0.
    for (int n = 0; n < 1000; n++) begin
      r   = RN'($urandom);
      r0v = ($urandom_range(0, 7) != 0) ? r[0] : ~r[0];
      p   = expand(r);
      e   = model(r0v, p);
      if (r0v == r[0]) check("model_matches_r", 32'(e.r), 32'(r));
      decode(r0v, p, e, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), -1, sc);
    end

    // Arbitrary streams exercise the consistency check.
    for (int n = 0; n < 200; n++) begin
      p   = NP'($urandom);
      r0v = 1'($urandom);
      decode(r0v, p, model(r0v, p), $urandom_range(0, 2), 1'b0, -1, sc);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
